bresp_demux_1to2: RTL

//  Write-response (B channel) stage paired with the 2:1 AW/W write mux.

---
 rtl/bresp_demux_1to2.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bresp_demux_1to2.sv
// B-channel demux for the 2:1 write mux: routes slave responses by BID MSB into a
// one-entry slot per master, tracks outstanding writes and drops stray responses.

module bresp_demux_slot #(
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            aw_acc,
  input  logic            load,
  input  logic [ID_W-1:0] bid_in,
  input  logic [1:0]      bresp_in,
  input  logic            bready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  output logic            aw_full,
  output logic            avail
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hs;

  assign hs = bvalid & bready;
  // Outstanding writes not already represented by the response sitting in the slot.
  assign avail = cnt > CNT_W'(bvalid);

  always_comb begin
    cnt_nxt = cnt;
    if (aw_acc && !hs && cnt != CNT_W'(MAX_OUT)) cnt_nxt = cnt + CNT_W'(1);
    else if (hs && !aw_acc)                      cnt_nxt = cnt - CNT_W'(1);
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      cnt     <= '0;
      aw_full <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      aw_full <= (cnt_nxt == CNT_W'(MAX_OUT));
      if (load) begin
        bvalid <= 1'b1;
        bid    <= bid_in;
        bresp  <= bresp_in;
      end else if (hs) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

module bresp_demux_1to2 #(
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            aw_acc_m1,
  input  logic            aw_acc_m2,
  input  logic [ID_W:0]   bid_s,
  input  logic [1:0]      bresp_s,
  input  logic            bvalid_s,
  output logic            bready_s,
  output logic [ID_W-1:0] bid_m1,
  output logic [ID_W-1:0] bid_m2,
  output logic [1:0]      bresp_m1,
  output logic [1:0]      bresp_m2,
  output logic            bvalid_m1,
  output logic            bvalid_m2,
  input  logic            bready_m1,
  input  logic            bready_m2,
  output logic            aw_full_m1,
  output logic            aw_full_m2,
  output logic            stray_resp
);

  logic                      tgt, take;
  logic [1:0]                vld, rdy, acc, load, avail, full;
  logic [1:0][ID_W-1:0]      bid_o;
  logic [1:0][1:0]           rsp_o;

  assign tgt = bid_s[ID_W];
  assign rdy = {bready_m2, bready_m1};
  assign acc = {aw_acc_m2, aw_acc_m1};

  // Ready does not wait on bvalid_s; a draining slot may be refilled in the same cycle.
  assign bready_s = ~vld[tgt] | rdy[tgt];
  assign take     = bvalid_s & bready_s;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign load[g] = take & (tgt == 1'(g)) & avail[g];
    bresp_demux_slot #(.ID_W(ID_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_slot (
      .aclk    (aclk),
      .areset  (areset),
      .aw_acc  (acc[g]),
      .load    (load[g]),
      .bid_in  (bid_s[ID_W-1:0]),
      .bresp_in(bresp_s),
      .bready  (rdy[g]),
      .bid     (bid_o[g]),
      .bresp   (rsp_o[g]),
      .bvalid  (vld[g]),
      .aw_full (full[g]),
      .avail   (avail[g])
    );
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) stray_resp <= 1'b0;
    else         stray_resp <= take & ~avail[tgt];
  end

  assign bid_m1     = bid_o[0];
  assign bid_m2     = bid_o[1];
  assign bresp_m1   = rsp_o[0];
  assign bresp_m2   = rsp_o[1];
  assign bvalid_m1  = vld[0];
  assign bvalid_m2  = vld[1];
  assign aw_full_m1 = full[0];
  assign aw_full_m2 = full[1];

endmodule
